// File: rtl/pad_uart_rx.sv
// pad_uart_rx: 8N1-style serial receiver fed straight from the input pad.
// Synchronises rxd_in, times bit centres with a baud counter and hands each
// received byte to the core through a single-entry valid/ready holding register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for rxd_s = 0
// S_START | timing to mid start bit, reject glitches as false starts
// S_DATA  | sampling DATA_BITS data bits at bit centres, LSB first
// S_STOP  | sampling stop bit; 1 completes the byte, 0 is a framing error
// S_BREAK | line held low after a framing error; wait for it to go high
module pad_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 rxd_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   done_q, done_d;
    logic                   frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   rxd_s;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; idle line level is 1
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd_in};
    end

    // Receive FSM: baud counter, bit counter and data shifter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxd_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = BIT_LAST;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == '0) state_d = S_STOP;
                    else bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxd_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: a completion may coincide with an accept of the old byte
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule
